// File: rtl/controle_escrita_if.sv
// rtl/controle_escrita_if.sv - requester handshakes and register-bank write port of controle_escrita
interface controle_escrita_if #(
    parameter int LARG = 16
);
    logic            valido0;
    logic [3:0]      reg0;
    logic [LARG-1:0] dado0;
    logic            pronto0;
    logic            valido1;
    logic [3:0]      reg1;
    logic [LARG-1:0] dado1;
    logic            pronto1;
    logic            sinal;
    logic [3:0]      entrada3;
    logic [LARG-1:0] dado;
    logic [15:0]     pendente;
    logic            ocioso;

    modport master (
        output valido0, reg0, dado0, valido1, reg1, dado1,
        input  pronto0, pronto1, sinal, entrada3, dado, pendente, ocioso
    );

    modport slave (
        input  valido0, reg0, dado0, valido1, reg1, dado1,
        output pronto0, pronto1, sinal, entrada3, dado, pendente, ocioso
    );
endinterface

// File: rtl/controle_escrita.sv
// rtl/controle_escrita.sv - round-robin write-port arbiter with per-requester FIFOs
// Two writeback sources share the bank write port; pendente exposes in-flight destinations.
module controle_escrita #(
    parameter int PROF = 2,
    parameter int LARG = 16
) (
    input  logic                clk,
    input  logic                reset,
    controle_escrita_if.slave   bus
);
    localparam int CW = $clog2(PROF + 1);
    localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam logic [CW-1:0] PROF_C = CW'(PROF);
    localparam logic [PW-1:0] PTR_LAST = PW'(PROF - 1);

    logic            w_gnt_valid;
    logic            w_gnt_idx;
    logic            r_ultimo;
    logic            r_sinal;
    logic [3:0]      r_entrada3;
    logic [LARG-1:0] r_dado;

    for (genvar n = 0; n < 2; n++) begin : g_fifo
        logic [3:0]      r_mreg  [PROF];
        logic [LARG-1:0] r_mdado [PROF];
        logic [PROF-1:0] r_vld;
        logic [PW-1:0]   r_wptr;
        logic [PW-1:0]   r_rptr;
        logic [CW-1:0]   r_count;
        logic            w_valido_in;
        logic [3:0]      w_reg_in;
        logic [LARG-1:0] w_dado_in;
        logic            w_pronto;
        logic            w_push;
        logic            w_pop;
        logic            w_nempty;
        logic [3:0]      w_head_reg;
        logic [LARG-1:0] w_head_dado;
        logic [15:0]     w_pend;

        assign w_valido_in = (n == 0) ? bus.valido0 : bus.valido1;
        assign w_reg_in    = (n == 0) ? bus.reg0    : bus.reg1;
        assign w_dado_in   = (n == 0) ? bus.dado0   : bus.dado1;

        // Space is judged on pre-edge occupancy: a same-cycle pop never frees room for a push.
        assign w_pronto    = !reset && (r_count < PROF_C);
        assign w_push      = w_valido_in && w_pronto;
        assign w_pop       = w_gnt_valid && (w_gnt_idx == 1'(n));
        assign w_nempty    = (r_count != '0);
        assign w_head_reg  = r_mreg[r_rptr];
        assign w_head_dado = r_mdado[r_rptr];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mreg[r_wptr]  <= w_reg_in;
                r_mdado[r_wptr] <= w_dado_in;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld   <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_vld[r_wptr] <= 1'b1;
                    r_wptr        <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_vld[r_rptr] <= 1'b0;
                    r_rptr        <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        always_comb begin
            w_pend = '0;
            for (int i = 0; i < PROF; i++) begin
                if (r_vld[i]) begin
                    w_pend[r_mreg[i]] = 1'b1;
                end
            end
        end
    end

    // With both FIFOs occupied the requester that did not win last time is served.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = 1'b0;
        if (g_fifo[0].w_nempty && g_fifo[1].w_nempty) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = ~r_ultimo;
        end else if (g_fifo[0].w_nempty) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = 1'b0;
        end else if (g_fifo[1].w_nempty) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sinal    <= 1'b0;
            r_entrada3 <= '0;
            r_dado     <= '0;
            r_ultimo   <= 1'b1;
        end else begin
            r_sinal <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_entrada3 <= w_gnt_idx ? g_fifo[1].w_head_reg  : g_fifo[0].w_head_reg;
                r_dado     <= w_gnt_idx ? g_fifo[1].w_head_dado : g_fifo[0].w_head_dado;
                r_ultimo   <= w_gnt_idx;
            end
        end
    end

    logic [15:0] w_pend_out;
    always_comb begin
        w_pend_out = '0;
        if (r_sinal) begin
            w_pend_out[r_entrada3] = 1'b1;
        end
    end

    assign bus.pronto0  = g_fifo[0].w_pronto;
    assign bus.pronto1  = g_fifo[1].w_pronto;
    assign bus.sinal    = r_sinal;
    assign bus.entrada3 = r_entrada3;
    assign bus.dado     = r_dado;
    assign bus.pendente = reset ? 16'h0000 : (g_fifo[0].w_pend | g_fifo[1].w_pend | w_pend_out);
    assign bus.ocioso   = reset || (!g_fifo[0].w_nempty && !g_fifo[1].w_nempty && !r_sinal);
endmodule

// File: tb/tb_controle_escrita.sv
// tb/tb_controle_escrita.sv - scoreboard bench for controle_escrita
module tb_controle_escrita;
    localparam int PROF = 2;
    localparam int LARG = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controle_escrita_if #(.LARG(LARG)) bus ();

    controle_escrita #(.PROF(PROF), .LARG(LARG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [19:0] exp_q[$];
    logic        m_sinal;
    logic [3:0]  m_ent;
    logic [15:0] m_dado;
    logic        m_ultimo;
    logic [15:0] bank_dut [16];
    bit          acc0, acc1;
    int          low1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] model_pend();
        logic [15:0] p = '0;
        if (reset) return '0;
        foreach (q0[i]) p[q0[i][19:16]] = 1'b1;
        foreach (q1[i]) p[q1[i][19:16]] = 1'b1;
        if (m_sinal) p[m_ent] = 1'b1;
        return p;
    endfunction

    task automatic cycle(input bit do_chk);
        logic [19:0] e;
        logic [19:0] head;
        bit ne0, ne1, gnt, idx;
        #1;
        if (do_chk) begin
            chk("pronto0", bus.pronto0, !reset && (q0.size() < PROF));
            chk("pronto1", bus.pronto1, !reset && (q1.size() < PROF));
            chk("sinal", bus.sinal, m_sinal);
            if (bus.sinal) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_write", bus.sinal, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_reg", bus.entrada3, e[19:16]);
                    chk("wr_dado", bus.dado, e[15:0]);
                    bank_dut[bus.entrada3] = bus.dado;
                end
            end else begin
                chk("hold_reg", bus.entrada3, m_ent);
                chk("hold_dado", bus.dado, m_dado);
            end
            chk("pendente", bus.pendente, model_pend());
            chk("ocioso", bus.ocioso, reset || (q0.size() == 0 && q1.size() == 0 && !m_sinal));
        end
        if (!bus.pronto1) low1++;
        acc0 = bus.valido0 && !reset && (q0.size() < PROF);
        acc1 = bus.valido1 && !reset && (q1.size() < PROF);
        if (reset) begin
            q0.delete(); q1.delete(); exp_q.delete();
            m_sinal = 0; m_ent = 0; m_dado = 0; m_ultimo = 1;
            acc0 = 0; acc1 = 0;
        end else begin
            ne0 = q0.size() > 0;
            ne1 = q1.size() > 0;
            gnt = ne0 || ne1;
            idx = (ne0 && ne1) ? !m_ultimo : ne1;
            if (gnt) begin
                head = idx ? q1.pop_front() : q0.pop_front();
                exp_q.push_back(head);
                m_ent = head[19:16];
                m_dado = head[15:0];
                m_ultimo = idx;
            end
            m_sinal = gnt;
            if (acc0) q0.push_back({bus.reg0, bus.dado0});
            if (acc1) q1.push_back({bus.reg1, bus.dado1});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.valido0 = 0;
        bus.valido1 = 0;
    endtask

    initial begin
        int i0, i1, c;
        m_sinal = 0; m_ent = 0; m_dado = 0; m_ultimo = 1;
        foreach (bank_dut[i]) bank_dut[i] = '0;

        // reset with both requesters offering
        reset = 1;
        bus.valido0 = 1; bus.reg0 = 4'd3; bus.dado0 = 16'hdead;
        bus.valido1 = 1; bus.reg1 = 4'd4; bus.dado1 = 16'hbeef;
        cycle(0);
        cycle(1);
        reset = 0;
        idle();
        cycle(1);

        // single write
        bus.valido0 = 1; bus.reg0 = 4'd5; bus.dado0 = 16'h1234;
        cycle(1);
        idle();
        repeat (4) cycle(1);
        chk("bank_r5", bank_dut[5], 16'h1234);

        // round-robin contention
        reset = 1; cycle(1); reset = 0;
        i0 = 0; i1 = 0;
        for (c = 0; c < 100 && (i0 < 8 || i1 < 8); c++) begin
            bus.valido0 = (i0 < 8); bus.reg0 = 4'(1 + i0); bus.dado0 = 16'(16'h1000 + i0);
            bus.valido1 = (i1 < 8); bus.reg1 = 4'(9 + i1); bus.dado1 = 16'(16'h9000 + i1);
            cycle(1);
            if (acc0) i0++;
            if (acc1) i1++;
        end
        chk("rr_sent0", i0, 8);
        chk("rr_sent1", i1, 8);
        idle();
        repeat (6) cycle(1);

        // backpressure hold on requester 1
        low1 = 0;
        i0 = 0; i1 = 0;
        for (c = 0; c < 60 && i1 < 4; c++) begin
            bus.valido0 = 1; bus.reg0 = 4'(i0); bus.dado0 = 16'(16'h2000 + i0);
            bus.valido1 = 1; bus.reg1 = 4'(12 + i1); bus.dado1 = 16'(16'h3000 + i1 * 16'h111);
            cycle(1);
            if (acc0) i0++;
            if (acc1) i1++;
        end
        chk("bp_sent1", i1, 4);
        chk("bp_pronto1_low_seen", (low1 > 0), 1'b1);
        idle();
        repeat (6) cycle(1);

        // same-register conflict, tie resolved towards requester 0
        reset = 1; cycle(1); reset = 0;
        bus.valido0 = 1; bus.reg0 = 4'd7; bus.dado0 = 16'hAAAA;
        bus.valido1 = 1; bus.reg1 = 4'd7; bus.dado1 = 16'h5555;
        cycle(1);
        idle();
        repeat (5) cycle(1);
        chk("bank_r7", bank_dut[7], 16'h5555);

        // reset mid-operation with full FIFOs
        for (int k = 0; k < 6; k++) begin
            bus.valido0 = 1; bus.reg0 = 4'(k); bus.dado0 = 16'(16'h4000 + k);
            bus.valido1 = 1; bus.reg1 = 4'(8 + k); bus.dado1 = 16'(16'h5000 + k);
            cycle(1);
        end
        reset = 1;
        cycle(1);
        reset = 0;
        idle();
        repeat (6) cycle(1);

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/controle_escrita.md
# controle_escrita

Write-port arbiter and scheduler for the 16×16-bit register bank. Two writeback sources (requester 0: ALU, requester 1: memory/load unit) share the bank's single write port (`sinal`, `entrada3`, `dado`). Each source has its own small FIFO with a valid/ready handshake. A round-robin scheduler drains at most one entry per cycle into registered write-port outputs. A pending-write mask is exported so issue logic can detect RAW hazards.

## Interface
- `PROF`, 2: FIFO depth per requester; legal values ≥1.
- `LARG`, 16: data width; must match the register bank.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `valido0` in 1: requester 0 offers a write.
- `reg0` in 4: requester 0 destination register.
- `dado0` in LARG: requester 0 write data.
- `pronto0` out 1: requester 0 FIFO can accept.
- `valido1`, `reg1`, `dado1`, `pronto1`: same as above, for requester 1.
- `sinal` out 1: register bank write enable (registered).
- `entrada3` out 4: register bank write address (registered).
- `dado` out LARG: register bank write data (registered).
- `pendente` out 16: bit r = 1 while any queued or output-stage entry targets register r.
- `ocioso` out 1: both FIFOs empty and `sinal`=0.

## Operation
- **Handshake**
  - Entry accepted at a posedge when `valido`n=1 and `pronto`n=1.
  - `pronto`n = !reset && (count n < PROF).
  - `pronto`n is based on occupancy before the edge. A same-cycle pop does not free space for a same-cycle push.
  - `reg`n/`dado`n are sampled only on acceptance.
  - `valido`n while `pronto`n=0 is ignored. The requester holds it; no entry is lost or duplicated.
- **FIFOs**
  - One per requester, PROF entries of {4-bit reg, LARG data}.
  - Read/write pointers wrap modulo PROF.
  - Occupancy counter width is clog2(PROF+1).
  - Push and pop in the same cycle leave the count unchanged.
- **Scheduler**
  - Each cycle, the candidate set = non-empty FIFOs.
  - One candidate: that FIFO is granted.
  - Two candidates: the requester not equal to `ultimo` is granted.
  - On a grant, the head is popped, `ultimo` is set to the granted index, and the output stage is loaded with `sinal`=1, `entrada3`=head reg, `dado`=head data.
  - No candidate: `sinal`=0. `entrada3`/`dado` hold their previous values.
- **Ordering**
  - Per-requester FIFO order is always preserved.
  - Writes from different requesters to the same register reach the bank in grant order. Issue logic uses `pendente` to avoid depending on that order.
- **pendente**
  - Combinational OR over all valid FIFO entries plus the output stage when `sinal`=1.
  - Register 0 is not special.
- **Reset** (synchronous; takes effect at the posedge where `reset`=1)
  - FIFOs emptied, pointers and counts cleared, `ultimo`=1 (requester 0 wins the first tie).
  - `sinal`=0, `entrada3`=0, `dado`=0.
  - `pendente`=0, `ocioso`=1, `pronto0`/`pronto1`=0 while `reset` is high.
  - A reset mid-operation discards all queued entries. No write is issued after the reset edge.

## Timing
- Acceptance at edge k → entry visible in the FIFO after k.
- Earliest grant at edge k+1 → `sinal`=1 during cycle k+1..k+2 → bank write at edge k+2. Minimum latency is 2 edges.
- Throughput: one bank write per cycle total. Each requester sustains 1/2 under full contention, or 1 when alone.
- `sinal` is high for exactly one cycle per granted entry.
- `pendente`[r] rises after the acceptance edge and falls after the edge at which the output stage drops (or reloads with another register).
- FIFO full: with both requesters pushing every cycle, occupancy grows one entry per two cycles per FIFO. `pronto`n drops the cycle after count reaches PROF.
- Empty with a simultaneous push: not eligible that cycle (no bypass). The grant comes the next cycle.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles with `valido0`=`valido1`=1 → `sinal`=0, `entrada3`=0, `dado`=0, `pendente`=0, `ocioso`=1, `pronto0`/`pronto1`=0. After release → `pronto0`/`pronto1`=1.
- **Single write.** One-cycle `valido0`, `reg0`=5, `dado0`=16'h1234 accepted at edge k → `sinal`=1, `entrada3`=5, `dado`=16'h1234 for exactly cycle k+1..k+2. `pendente`=16'h0020 from after k until after k+2. Bank R5 reads 16'h1234 afterwards.
- **Round-robin contention.** Both requesters push every cycle with `reg0`=1/2/3… and `reg1`=9/10/11… → grant order 0,1,0,1. First write goes to R1. `pronto0`/`pronto1` each drop once the count reaches 2. All 16 offered entries are written exactly once, each in its requester's order.
- **Backpressure hold.** Requester 1 alone pushes 4 entries back-to-back with PROF=2 while requester 0 saturates → `pronto1` low for at least one cycle. The held entry is accepted later, unchanged. No duplicates.
- **Same-register conflict.** `reg0`=`reg1`=7 with data 16'hAAAA/16'h5555 accepted at the same edge, `ultimo`=1 → `entrada3`=7 with 16'hAAAA, then 16'h5555 the next cycle. Final R7=16'h5555. `pendente`[7] stays high across both writes.
- **Reset mid-operation.** Both FIFOs full, then assert `reset` for 1 cycle → `sinal`=0 from the reset edge, no later write of a discarded entry, `ocioso`=1 after reset.
